// File: rtl/sha_msg_sched.sv
// SHA-2 message-schedule generator: takes 16 message words, emits W[0..ROUNDS-1]
// through a registered valid/ready port with round index and last flag.
module sha_msg_sched #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              m_valid_i,
  output logic              m_ready_o,
  input  logic [WORD_W-1:0] m_data_i,
  output logic              w_valid_o,
  input  logic              w_ready_i,
  output logic [WORD_W-1:0] w_data_o,
  output logic [6:0]        w_round_o,
  output logic              w_last_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2
  } state_e;

  localparam int S0A = (WORD_W == 64) ? 1  : 7;
  localparam int S0B = (WORD_W == 64) ? 8  : 18;
  localparam int S0C = (WORD_W == 64) ? 7  : 3;
  localparam int S1A = (WORD_W == 64) ? 19 : 17;
  localparam int S1B = (WORD_W == 64) ? 61 : 19;
  localparam int S1C = (WORD_W == 64) ? 6  : 10;
  localparam logic [6:0] LAST_RND = 7'(ROUNDS - 1);

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    return rotr(x, S0A) ^ rotr(x, S0B) ^ (x >> S0C);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    return rotr(x, S1A) ^ rotr(x, S1B) ^ (x >> S1C);
  endfunction

  state_e            state_q, state_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] win_q [16];
  logic              w_valid_q, w_valid_d;
  logic [WORD_W-1:0] w_data_q, w_data_d;
  logic [6:0]        w_round_q, w_round_d;
  logic              w_last_q, w_last_d;

  logic              out_free_s;
  logic              load_acc_s;
  logic              exp_go_s;
  logic              push_s;
  logic              at_last_s;
  logic [WORD_W-1:0] exp_word_s;
  logic [WORD_W-1:0] push_word_s;

  // win_q[0] is W[t-1], win_q[15] is W[t-16]
  assign exp_word_s  = sig1(win_q[1]) + win_q[6] + sig0(win_q[14]) + win_q[15];
  assign out_free_s  = !w_valid_q || w_ready_i;
  assign load_acc_s  = (state_q == LOAD) && m_valid_i && out_free_s;
  assign exp_go_s    = (state_q == EXPAND) && out_free_s;
  assign push_s      = load_acc_s || exp_go_s;
  assign push_word_s = (state_q == LOAD) ? m_data_i : exp_word_s;
  assign at_last_s   = (cnt_q == LAST_RND);

  assign m_ready_o = (state_q == LOAD) && out_free_s;
  assign busy_o    = (state_q != IDLE);
  assign w_valid_o = w_valid_q;
  assign w_data_o  = w_data_q;
  assign w_round_o = w_round_q;
  assign w_last_o  = w_last_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          cnt_d   = 7'd0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (load_acc_s) begin
          cnt_d   = cnt_q + 7'd1;
          state_d = (cnt_q == 7'd15) ? EXPAND : LOAD;
        end else begin
          state_d = LOAD;
        end
      end
      EXPAND: begin
        if (exp_go_s) begin
          cnt_d   = cnt_q + 7'd1;
          state_d = at_last_s ? IDLE : EXPAND;
        end else begin
          state_d = EXPAND;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 7'd0;
      end
    endcase
  end

  always_comb begin
    w_valid_d = w_valid_q;
    w_data_d  = w_data_q;
    w_round_d = w_round_q;
    w_last_d  = w_last_q;
    if (push_s) begin
      w_valid_d = 1'b1;
      w_data_d  = push_word_s;
      w_round_d = cnt_q;
      w_last_d  = at_last_s;
    end else if (w_ready_i) begin
      w_valid_d = 1'b0;
    end else begin
      w_valid_d = w_valid_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= 7'd0;
      w_valid_q <= 1'b0;
      w_data_q  <= '0;
      w_round_q <= 7'd0;
      w_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      w_valid_q <= w_valid_d;
      w_data_q  <= w_data_d;
      w_round_q <= w_round_d;
      w_last_q  <= w_last_d;
    end
  end

  // Not cleared between blocks: LOAD overwrites all 16 entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_q <= '{default: '0};
    end else if (push_s) begin
      win_q[0] <= push_word_s;
      for (int i = 1; i < 16; i++) begin
        win_q[i] <= win_q[i-1];
      end
    end
  end

endmodule

// File: doc/sha_msg_sched.md
# sha_msg_sched

Parametrised SHA-2 message-schedule generator producing the round-word stream W[0..ROUNDS-1] for one 512-bit (SHA-256) or 1024-bit (SHA-512) block. It accepts the 16 message words through a valid/ready input port and emits every W[t] through a registered valid/ready output port with round index and last flag. It sits between the block padder and the compression core, replacing the fixed 32-bit, externally counted scheduler with a self-sequencing, back-pressure-aware, width-generic one.

## Interface

- WORD_W, 32, word width; legal values are only 32 (SHA-256 sigmas) and 64 (SHA-512 sigmas).
- ROUNDS, 64, total words emitted per block; legal values are 64 (with WORD_W=32) and 80 (with WORD_W=64).
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset).
- start  in  1  pulse that begins one block; sampled only in IDLE.
- m_valid  in  1  message word valid.
- m_ready  out  1  scheduler accepts message word.
- m_data  in  WORD_W  message word, big-endian word order (word 0 first).
- w_valid  out  1  output round word valid.
- w_ready  in  1  consumer accepts round word.
- w_data  out  WORD_W  W[t].
- w_round  out  7  t of the word on w_data (0..ROUNDS-1).
- w_last  out  1  high with w_valid when t = ROUNDS-1.
- busy  out  1  high in LOAD or EXPAND.

## Operation

- Window: 16 × WORD_W shift register r[0..15]; r[0] holds W[t-1], r[15] holds W[t-16]. A push shifts r[i] <= r[i-1] and writes r[0].
- Expansion word: W[t] = σ1(r[1]) + r[6] + σ0(r[14]) + r[15], computed modulo 2^WORD_W with carries discarded.
- WORD_W=32: σ0 = ROTR7 ^ ROTR18 ^ SHR3; σ1 = ROTR17 ^ ROTR19 ^ SHR10.
- WORD_W=64: σ0 = ROTR1 ^ ROTR8 ^ SHR7; σ1 = ROTR19 ^ ROTR61 ^ SHR6.
- out_free = !w_valid || w_ready.
- FSM states:
  - IDLE: start=1 → LOAD, round counter cnt <= 0.
  - LOAD: m_ready = out_free. On m_valid && m_ready, push m_data, load the output register with {m_data, cnt}, and cnt++. When cnt=15 is accepted → EXPAND.
  - EXPAND: when out_free, push the computed W[t], load the output register with it, and cnt++. When cnt = ROUNDS-1 is issued (w_last=1) → IDLE.
- m_ready is 0 in IDLE and in EXPAND.
- start in LOAD or EXPAND is ignored. start and a new block may be issued in IDLE while the last word is still held on the output.
- The window is not cleared between blocks; all 16 entries are overwritten during LOAD.

## Timing

- Reset values: m_ready=0, w_valid=0, w_data=0, w_round=0, w_last=0, busy=0, FSM=IDLE, window=0.
- Reset mid-block aborts immediately. No partial words are emitted after release.
- start high at edge k puts busy=1 and makes m_ready eligible from cycle k+1.
- Latency is 1 cycle: a word accepted at edge n appears on w_data with w_valid=1 after edge n.
- Throughput is 1 word/cycle with w_ready held high. A block takes 16 + (ROUNDS-16) cycles after start, with no bubble at the LOAD→EXPAND boundary.
- w_valid, w_data, w_round and w_last are registered. They must stay stable while w_valid && !w_ready.
- With w_ready=0 and w_valid=1, neither the window nor cnt advances, and m_ready=0.
- busy falls on the edge that loads the round ROUNDS-1 word.

## Test plan

- SHA-256 "abc": load 0x61626380, 14×0, 0x00000018 with w_ready=1 → W16=0x61626380, W17=0x000F0000, and exactly 64 words with w_last only at w_round=63. Full stream must match the reference model.
- SHA-512 (WORD_W=64, ROUNDS=80) "abc": load 0x6162638000000000, 14×0, 0x18 → W16=0x6162638000000000, W17=0x00030000000000C0, 80 words, w_last at 79.
- Random back-pressure (w_ready ~50%) and random m_valid gaps → word stream identical to the no-stall run; output held stable while stalled; m_ready=0 whenever w_valid && !w_ready.
- Reset asserted at round 30 (async, between edges) → all outputs at reset values immediately. Next start plus a fresh block yields the correct full stream.
- start pulsed during LOAD and during EXPAND → ignored, no count disturbance. Back-to-back blocks with start in the cycle after w_last → second block correct; words 0..15 pass through unchanged.
- m_valid high in IDLE before start → m_ready=0 and nothing accepted.
